sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8: data width in bits.
REQ-002 Parameter DEPTH, default 16: entries; power of two, >= 4.
REQ-003 Parameter ALM_FULL_TH, default DEPTH-2: almost-full threshold in entries.
REQ-004 Parameter ALM_EMPTY_TH, default 2: almost-empty threshold in entries.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 i_wren  input  1  write request.
REQ-008 i_wrdata  input  DATA_W  write data, sampled with i_wren.
REQ-009 i_rden  input  1  read request.
REQ-010 o_rddata  output  DATA_W  read data, registered.
REQ-011 o_full  output  1  count == DEPTH.
REQ-012 o_empty  output  1  count == 0.
REQ-013 o_alm_full  output  1  count >= ALM_FULL_TH.
REQ-014 o_alm_empty  output  1  count <= ALM_EMPTY_TH.
REQ-015 o_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Write accepted at a rising edge iff i_wren=1 and o_full=0; accepted data stored at the write pointer, which then advances by 1.
REQ-017 Read accepted at a rising edge iff i_rden=1 and o_empty=0; the head word is loaded into o_rddata at that edge and the read pointer advances by 1.
REQ-018 Read latency: exactly one cycle; o_rddata holds its value in every cycle with no accepted read.
REQ-019 Pointers: $clog2(DEPTH) bits each; wrap from DEPTH-1 to 0 with no gap or special case.
REQ-020 Count: +1 on write-only, -1 on read-only, unchanged on both or neither accepted; never exceeds DEPTH or goes below 0.
REQ-021 Full with i_wren=1 and i_rden=1: read accepted, write rejected; count becomes DEPTH-1.
REQ-022 Empty with i_wren=1 and i_rden=1: write accepted, read rejected; no fall-through; o_rddata unchanged; count becomes 1.
REQ-023 Rejected writes and reads leave memory, pointers, count and o_rddata unchanged.
REQ-024 All flags are decoded from the registered count only; they reflect the count after the same edge, with no input-to-output combinational path.
REQ-025 Data order is strictly first-in first-out.

Reset
REQ-026 rst=1 at a rising edge: pointers=0, o_count=0, o_rddata=0, o_empty=1, o_full=0, o_alm_full=0, o_alm_empty=1.
REQ-027 rst takes priority over any simultaneous i_wren/i_rden; mid-operation, all stored entries are discarded and no write or read is accepted in that cycle.
REQ-028 Memory array contents are not reset and are unobservable until rewritten.

Configuration
REQ-029 Macro SYNC_FIFO_ERR_FLAGS_EN defined: adds outputs o_overflow (1) and o_underflow (1), both registered and reset to 0.
REQ-030 With the macro: o_overflow=1 for exactly the cycle after an edge with i_wren=1 and o_full=1 and write rejected; o_underflow=1 for exactly the cycle after an edge with i_rden=1 and o_empty=1.
REQ-031 Without the macro: neither port nor its logic exists; all other behaviour is identical.

Verification (DATA_W=8, DEPTH=16, ALM_FULL_TH=14, ALM_EMPTY_TH=2)
REQ-032 Reset, then write 0x00..0x0F in 16 cycles -> o_alm_empty drops after the 3rd write, o_alm_full rises after the 14th, o_full=1 and o_count=16 after the 16th.
REQ-033 From full, 16 reads -> o_rddata = 0x00..0x0F, each one cycle after its read edge; o_empty=1 after the last.
REQ-034 Full, write 0xAA with i_rden=1 -> 0x00 read out, 0xAA dropped, o_count=15; with macro, o_overflow pulses 1 cycle.
REQ-035 Empty, write 0x55 with i_rden=1 -> o_rddata unchanged, o_count=1; the next read returns 0x55.
REQ-036 Fill 10, drain 10, repeat 3x (pointer wrap) -> output sequence equals input sequence, no loss.
REQ-037 At o_count=9, assert rst with i_wren=1 -> next cycle o_count=0, o_empty=1, o_rddata=0x00.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and count-decoded flags; define SYNC_FIFO_ERR_FLAGS_EN for o_overflow/o_underflow.
module sync_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ALM_FULL_TH  = DEPTH - 2,
    parameter int ALM_EMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wren,
    input  logic [DATA_W-1:0]        i_wrdata,
    input  logic                     i_rden,
    output logic [DATA_W-1:0]        o_rddata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_alm_full,
    output logic                     o_alm_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic                     o_overflow,
    output logic                     o_underflow,
`endif
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp, rp;
    logic              wr_ok, rd_ok;
    assign wr_ok = i_wren && !o_full;
    assign rd_ok = i_rden && !o_empty;
    always_comb begin
        o_full      = o_count == CW'(DEPTH);
        o_empty     = o_count == '0;
        o_alm_full  = o_count >= CW'(ALM_FULL_TH);
        o_alm_empty = o_count <= CW'(ALM_EMPTY_TH);
    end
    always_ff @(posedge clk)
        if (wr_ok && !rst) mem[wp] <= i_wrdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            o_count  <= '0;
            o_rddata <= '0;
        end else begin
            if (wr_ok) wp <= wp + AW'(1);
            if (rd_ok) begin
                rp       <= rp + AW'(1);
                o_rddata <= mem[rp];
            end
            o_count <= o_count + CW'(wr_ok) - CW'(rd_ok);
        end
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= i_wren && o_full;
            o_underflow <= i_rden && o_empty;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: table-driven fill/drain vectors plus scoreboarded corner sequences for sync_fifo.
module tb_sync_fifo;
    logic       clk = 0;
    logic       rst = 1;
    logic       i_wren = 0;
    logic [7:0] i_wrdata = '0;
    logic       i_rden = 0;
    logic [7:0] o_rddata;
    logic       o_full, o_empty, o_alm_full, o_alm_empty;
    logic [4:0] o_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       o_overflow, o_underflow;
`endif
    int checks = 0;
    int errors = 0;
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    logic [7:0] exp_rd = '0;

    sync_fifo #(.DATA_W(8), .DEPTH(16), .ALM_FULL_TH(14), .ALM_EMPTY_TH(2)) dut (
        .clk(clk), .rst(rst), .i_wren(i_wren), .i_wrdata(i_wrdata), .i_rden(i_rden),
        .o_rddata(o_rddata), .o_full(o_full), .o_empty(o_empty),
        .o_alm_full(o_alm_full), .o_alm_empty(o_alm_empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .o_overflow(o_overflow), .o_underflow(o_underflow),
`endif
        .o_count(o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       w;
        bit       r;
        bit [7:0] d;
        int       cnt;
        bit [7:0] rd;
        bit       full, empty, afull, aempty;
    } vec_t;
    vec_t vec [32];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags();
        int n = mq.size();
        chk("count", int'(o_count), n);
        chk("full", int'(o_full), int'(n == 16));
        chk("empty", int'(o_empty), int'(n == 0));
        chk("alm_full", int'(o_alm_full), int'(n >= 14));
        chk("alm_empty", int'(o_alm_empty), int'(n <= 2));
    endtask

    // Model decides acceptance from its own occupancy; read data goes through the scoreboard queue.
    task automatic step(input bit w, input logic [7:0] d, input bit r);
        bit wa = w && mq.size() < 16;
        bit ra = r && mq.size() > 0;
        i_wren = w; i_wrdata = d; i_rden = r;
        if (ra) sb.push_back(mq.pop_front());
        if (wa) mq.push_back(d);
        @(posedge clk); #1;
        if (ra) exp_rd = sb.pop_front();
        chk("rddata", int'(o_rddata), int'(exp_rd));
        chk_flags();
        i_wren = 0; i_rden = 0;
    endtask

    task automatic do_reset(input bit w);
        rst = 1; i_wren = w; i_wrdata = 8'hEE;
        @(posedge clk); #1;
        rst = 0; i_wren = 0;
        mq.delete(); sb.delete(); exp_rd = '0;
        chk("rst_rddata", int'(o_rddata), 0);
        chk_flags();
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            vec[i] = '{w:1, r:0, d:8'(i), cnt:i + 1, rd:8'h00, full:(i == 15), empty:0,
                       afull:(i + 1 >= 14), aempty:(i + 1 <= 2)};
        for (int k = 0; k < 16; k++)
            vec[16 + k] = '{w:0, r:1, d:8'h00, cnt:15 - k, rd:8'(k), full:0, empty:(k == 15),
                            afull:(15 - k >= 14), aempty:(15 - k <= 2)};
        @(posedge clk); #1;
        do_reset(0);
        step(0, 8'h00, 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("underflow", int'(o_underflow), 1);
`endif
        foreach (vec[i]) begin
            step(vec[i].w, vec[i].d, vec[i].r);
            chk("vec_count", int'(o_count), vec[i].cnt);
            chk("vec_rddata", int'(o_rddata), int'(vec[i].rd));
            chk("vec_full", int'(o_full), int'(vec[i].full));
            chk("vec_empty", int'(o_empty), int'(vec[i].empty));
            chk("vec_afull", int'(o_alm_full), int'(vec[i].afull));
            chk("vec_aempty", int'(o_alm_empty), int'(vec[i].aempty));
        end
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        step(1, 8'hAA, 1);
        chk("full_rw_rddata", int'(o_rddata), 8'h00);
        chk("full_rw_count", int'(o_count), 15);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow", int'(o_overflow), 1);
        step(0, 8'h00, 0);
        chk("overflow_clr", int'(o_overflow), 0);
`endif
        for (int i = 0; i < 15; i++) step(0, 8'h00, 1);
        chk("drain_last", int'(o_rddata), 8'h0F);
        step(1, 8'h55, 1);
        chk("empty_rw_rddata", int'(o_rddata), 8'h0F);
        chk("empty_rw_count", int'(o_count), 1);
        step(0, 8'h00, 1);
        chk("empty_rw_next", int'(o_rddata), 8'h55);
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 10; i++) step(1, 8'($urandom_range(1, 255)), 0);
            for (int i = 0; i < 10; i++) step(0, 8'h00, 1);
        end
        chk("wrap_sb_empty", sb.size(), 0);
        for (int i = 0; i < 9; i++) step(1, 8'(8'h30 + i), 0);
        step(0, 8'h00, 1);
        chk("pre_rst_count", int'(o_count), 8);
        step(1, 8'h39, 0);
        chk("pre_rst_count9", int'(o_count), 9);
        do_reset(1);
        step(0, 8'h00, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
